// File: rtl/val2_pkg.sv
// Shared definitions for the Val2 shift sequencer: shift opcodes, FSM states and
// the STEP_BITS legality rule.
package val2_pkg;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   function automatic bit step_bits_legal(int unsigned step);
      return (step == 1) || (step == 2) || (step == 4) || (step == 8);
   endfunction

endpackage

// File: rtl/val2_step_unit.sv
// One iteration of the Val2 shifter: shift/rotate work by k (k <= STEP_BITS) positions.
module val2_step_unit
   import val2_pkg::*;
(
   input  logic [31:0] work,
   input  logic [1:0]  op,
   input  logic [4:0]  k,
   input  logic        fill,
   output logic [31:0] result
);

   logic [5:0] kk;
   logic [5:0] inv;

   assign kk  = {1'b0, k};
   assign inv = 6'd32 - kk;

   // A shift by inv == 32 yields zero, so k == 0 degenerates cleanly to a pass-through.
   always_comb begin
      result = work;
      unique case (op)
         SH_LSL:  result = work << kk;
         SH_LSR:  result = work >> kk;
         SH_ASR:  result = (work >> kk) | ({32{fill}} << inv);
         SH_ROR:  result = (work >> kk) | (work << inv);
         default: result = work;
      endcase
   end

endmodule

// File: rtl/val2_shift_sequencer.sv
// Multi-cycle Val2 generator: latches the operand at start, shifts STEP_BITS per cycle,
// and publishes the result on val2 with a one-cycle done pulse.
module val2_shift_sequencer
   import val2_pkg::*;
#(
   parameter int unsigned STEP_BITS = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        start,
   input  logic [31:0] val_rm,
   input  logic        imm,
   input  logic        mem_cmd,
   input  logic [11:0] shift_operand,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [31:0] val2
);

   if (!step_bits_legal(STEP_BITS)) begin : g_illegal_step
      $error("val2_shift_sequencer: STEP_BITS must be 1, 2, 4 or 8");
   end

   localparam logic [4:0] STEP = 5'(STEP_BITS);

   state_t      state;
   logic [31:0] work;
   logic [1:0]  op;
   logic [4:0]  rem;
   logic        fill;

   logic [31:0] dec_work;
   logic [1:0]  dec_op;
   logic [4:0]  dec_amt;
   logic [4:0]  k;
   logic [31:0] step_out;

   // Operand decode; mem_cmd outranks imm, which outranks the register form.
   always_comb begin
      dec_work = val_rm;
      dec_op   = shift_operand[6:5];
      dec_amt  = shift_operand[11:7];
      if (mem_cmd) begin
         dec_work = {{20{shift_operand[11]}}, shift_operand};
         dec_op   = SH_LSL;
         dec_amt  = 5'd0;
      end else if (imm) begin
         dec_work = {24'b0, shift_operand[7:0]};
         dec_op   = SH_ROR;
         dec_amt  = {shift_operand[11:8], 1'b0};
      end
   end

   assign k = (rem < STEP) ? rem : STEP;

   val2_step_unit u_step (
      .work   (work),
      .op     (op),
      .k      (k),
      .fill   (fill),
      .result (step_out)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         work  <= '0;
         op    <= SH_LSL;
         rem   <= '0;
         fill  <= 1'b0;
         val2  <= '0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (!flush && start) begin
                  work <= dec_work;
                  op   <= dec_op;
                  rem  <= dec_amt;
                  fill <= val_rm[31];
                  if (dec_amt == 5'd0) begin
                     state <= S_DONE;
                     val2  <= dec_work;
                  end else begin
                     state <= S_SHIFT;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_SHIFT: begin
               if (flush) begin
                  state <= S_IDLE;
               end else begin
                  work <= step_out;
                  rem  <= rem - k;
                  if (rem == k) begin
                     state <= S_DONE;
                     val2  <= step_out;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign ready = (state == S_IDLE) || (state == S_DONE);
   assign busy  = (state == S_SHIFT);
   assign done  = (state == S_DONE);

endmodule
